// File: rtl/fir_resampler_phase_sched.sv
// Polyphase phase scheduler for an L/M rational FIR resampler: tracks the phase
// accumulator and input lag, and issues (phase, advance) compute commands.
module fir_resampler_phase_sched #(
  parameter int INTERPOLATION = 32,
  parameter int DECIMATION    = 25,
  parameter int LAG_MAX       = 8,
  parameter int PHASE_W       = $clog2(INTERPOLATION),
  parameter int ADV_W         = $clog2(DECIMATION / INTERPOLATION + 2),
  parameter int LAG_W         = $clog2(LAG_MAX + 1) + 1
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               enable_i,
  input  logic               data_val_i,
  output logic               cmd_val_o,
  input  logic               cmd_rdy_i,
  output logic [PHASE_W-1:0] cmd_phase_o,
  output logic [ADV_W-1:0]   cmd_adv_o,
  output logic [LAG_W-1:0]   lag_o,
  input  logic               err_clr_i,
  output logic [1:0]         err_flg_o
);

  localparam int unsigned ADV = DECIMATION / INTERPOLATION;
  localparam int unsigned REM = DECIMATION % INTERPOLATION;
  // Lag must also hold 0 minus the largest advance, which can exceed LAG_W for large M/L.
  localparam int LAG_IW = (LAG_W > ADV_W + 2) ? LAG_W : ADV_W + 2;

  if (INTERPOLATION < 2 || DECIMATION < 2 || INTERPOLATION == DECIMATION) begin : g_bad_params
    $error("fir_resampler_phase_sched: need L>=2, M>=2 and L!=M");
  end

  function automatic logic [PHASE_W:0] sum_of(input logic [PHASE_W-1:0] a);
    return {1'b0, a} + (PHASE_W + 1)'(REM);
  endfunction

  function automatic logic wraps(input logic [PHASE_W-1:0] a);
    return sum_of(a) >= (PHASE_W + 1)'(INTERPOLATION);
  endfunction

  function automatic logic [ADV_W-1:0] adv_of(input logic [PHASE_W-1:0] a);
    return wraps(a) ? ADV_W'(ADV + 1) : ADV_W'(ADV);
  endfunction

  function automatic logic [PHASE_W-1:0] step_of(input logic [PHASE_W-1:0] a);
    logic [PHASE_W:0] t;
    t = wraps(a) ? sum_of(a) - (PHASE_W + 1)'(INTERPOLATION) : sum_of(a);
    return t[PHASE_W-1:0];
  endfunction

  logic [PHASE_W-1:0]      acc;
  logic [PHASE_W-1:0]      acc_nx;
  logic [LAG_IW-1:0]       lag;
  logic signed [LAG_IW:0]  lag_calc;
  logic [ADV_W-1:0]        adv_take;
  logic                    accept;
  logic                    ovf;

  always_comb begin
    accept   = cmd_val_o & cmd_rdy_i;
    adv_take = accept ? adv_of(acc) : '0;
    acc_nx   = accept ? step_of(acc) : acc;
    lag_calc = $signed({lag[LAG_IW-1], lag})
             + $signed({{LAG_IW{1'b0}}, data_val_i})
             - $signed({{(LAG_IW + 1 - ADV_W){1'b0}}, adv_take});
    ovf      = lag_calc > $signed((LAG_IW + 1)'(LAG_MAX));
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      acc         <= '0;
      lag         <= '1;
      cmd_val_o   <= 1'b0;
      cmd_phase_o <= '0;
      cmd_adv_o   <= '0;
      err_flg_o   <= '0;
    end else begin
      // Set events are OR-ed after the clear so they win over err_clr_i.
      err_flg_o <= (err_clr_i ? 2'b00 : err_flg_o)
                 | {data_val_i & ~enable_i, enable_i & ovf};
      if (!enable_i) begin
        acc         <= '0;
        lag         <= '1;
        cmd_val_o   <= 1'b0;
        cmd_phase_o <= '0;
        cmd_adv_o   <= '0;
      end else begin
        acc         <= acc_nx;
        lag         <= ovf ? LAG_IW'(LAG_MAX) : lag_calc[LAG_IW-1:0];
        cmd_val_o   <= ~lag_calc[LAG_IW];
        cmd_phase_o <= acc_nx;
        cmd_adv_o   <= adv_of(acc_nx);
      end
    end
  end

  assign lag_o = lag[LAG_W-1:0];

endmodule

// File: tb/tb_fir_resampler_phase_sched.sv
// Bench for fir_resampler_phase_sched: two configurations (L=3/M=2 and L=2/M=5)
// driven in lockstep and compared each cycle against a sample/output counting model.
module tb_fir_resampler_phase_sched;

  localparam int LA = 3, MA = 2, LB = 2, MB = 5, LAGMAX = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, en, dv, rdy, clr;

  logic       val_a, val_b;
  logic [1:0] ph_a;
  logic [0:0] ph_b;
  logic [0:0] adv_a;
  logic [1:0] adv_b;
  logic [4:0] lag_a, lag_b;
  logic [1:0] err_a, err_b;

  fir_resampler_phase_sched #(
    .INTERPOLATION(LA), .DECIMATION(MA), .LAG_MAX(LAGMAX),
    .PHASE_W(2), .ADV_W(1), .LAG_W(5)
  ) u_a (
    .clk_i(clk), .rst_n_i(rst_n), .enable_i(en), .data_val_i(dv),
    .cmd_val_o(val_a), .cmd_rdy_i(rdy), .cmd_phase_o(ph_a), .cmd_adv_o(adv_a),
    .lag_o(lag_a), .err_clr_i(clr), .err_flg_o(err_a)
  );

  fir_resampler_phase_sched #(
    .INTERPOLATION(LB), .DECIMATION(MB), .LAG_MAX(LAGMAX),
    .PHASE_W(1), .ADV_W(2), .LAG_W(5)
  ) u_b (
    .clk_i(clk), .rst_n_i(rst_n), .enable_i(en), .data_val_i(dv),
    .cmd_val_o(val_b), .cmd_rdy_i(rdy), .cmd_phase_o(ph_b), .cmd_adv_o(adv_b),
    .lag_o(lag_b), .err_clr_i(clr), .err_flg_o(err_b)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: samples kept (n) and commands accepted (k) per configuration.
  int     ml[2] = '{LA, LB};
  int     mm[2] = '{MA, MB};
  longint n[2], k[2];
  bit     ev[2];
  int     eph[2], eadv[2], elag[2];
  bit [1:0] eerr[2];

  // Output k consumes input samples up to index floor(k*M/L).
  function automatic longint need(longint kk, int m, int l);
    return (kk * m) / l + 1;
  endfunction

  task automatic model_step(input int i);
    longint n2, k2;
    bit s0, s1;
    s0 = 1'b0;
    s1 = dv & ~en;
    if (!rst_n) begin
      n[i] = 0; k[i] = 0; ev[i] = 0; eph[i] = 0; eadv[i] = 0; elag[i] = -1; eerr[i] = 2'b00;
      return;
    end
    if (!en) begin
      n[i] = 0; k[i] = 0; ev[i] = 0; eph[i] = 0; eadv[i] = 0; elag[i] = -1;
    end else begin
      k2 = k[i] + ((ev[i] && rdy) ? 1 : 0);
      n2 = n[i] + (dv ? 1 : 0);
      if (n2 - need(k2, mm[i], ml[i]) > LAGMAX) begin
        n2 = n[i];
        s0 = 1'b1;
      end
      n[i] = n2;
      k[i] = k2;
      elag[i] = int'(n[i] - need(k[i], mm[i], ml[i]));
      ev[i]   = elag[i] >= 0;
      eph[i]  = int'((k[i] * mm[i]) % ml[i]);
      eadv[i] = int'(need(k[i] + 1, mm[i], ml[i]) - need(k[i], mm[i], ml[i]));
    end
    eerr[i] = (clr ? 2'b00 : eerr[i]) | {s1, s0};
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick(input bit dv_, input bit rdy_, input bit en_, input bit clr_, input bit rst_n_);
    @(negedge clk);
    dv = dv_; rdy = rdy_; en = en_; clr = clr_; rst_n = rst_n_;
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    chk("a_val", int'(val_a), int'(ev[0]));
    chk("a_phase", int'(ph_a), eph[0]);
    chk("a_adv", int'(adv_a), eadv[0]);
    chk("a_lag", int'($signed(lag_a)), elag[0]);
    chk("a_err", int'(err_a), int'(eerr[0]));
    chk("b_val", int'(val_b), int'(ev[1]));
    chk("b_phase", int'(ph_b), eph[1]);
    chk("b_adv", int'(adv_b), eadv[1]);
    chk("b_lag", int'($signed(lag_b)), elag[1]);
    chk("b_err", int'(err_b), int'(eerr[1]));
  endtask

  initial begin
    dv = 0; rdy = 0; en = 0; clr = 0; rst_n = 0;
    // Reset state
    tick(0, 0, 0, 0, 0);
    tick(0, 0, 1, 0, 0);
    // L=3/M=2 pattern: one input every 4 cycles, always ready
    for (int i = 0; i < 24; i++) tick(i % 4 == 0, 1, 1, 0, 1);
    // Continuous input: L=2/M=5 rate limiting, L=3/M=2 builds lag and overflows
    for (int i = 0; i < 30; i++) tick(1, 1, 1, 0, 1);
    tick(0, 1, 1, 1, 1);
    // Stall with input pulses: payload held, lag saturates
    for (int i = 0; i < 12; i++) tick(i % 2 == 0, 0, 1, 0, 1);
    tick(0, 0, 1, 1, 1);
    tick(1, 0, 1, 1, 1);
    for (int i = 0; i < 12; i++) tick(0, 1, 1, 0, 1);
    // Disable while a command is pending, input while disabled, re-enable
    tick(1, 0, 1, 0, 1);
    tick(0, 0, 0, 0, 1);
    tick(1, 0, 0, 0, 1);
    tick(0, 1, 1, 0, 1);
    tick(1, 1, 1, 0, 1);
    for (int i = 0; i < 6; i++) tick(0, 1, 1, 0, 1);
    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      tick($urandom_range(0, 99) < 55,
           $urandom_range(0, 99) < 70,
           $urandom_range(0, 99) < 95,
           $urandom_range(0, 99) < 4,
           $urandom_range(0, 99) < 98);
    end
    // Mid-stream one-cycle reset, then restart
    for (int i = 0; i < 5; i++) tick(1, 1, 1, 0, 1);
    tick(1, 1, 1, 0, 0);
    for (int i = 0; i < 10; i++) tick(i % 2 == 0, 1, 1, 0, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
